// File: rtl/pipelined_barrel_shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
// Shared types, defaults and elaboration-time helpers for the pipelined
// barrel shifter.
//   shift_op_e       : operation encoding (00 SLL, 01 SRL, 10 SRA, 11 ROL)
//   DEFAULT_*        : default data width and register-slot count
//   stage_slot()     : register slot that evaluates a given mux stage
//   slot_last_stage(): last mux stage evaluated inside a given slot
// -----------------------------------------------------------------------------
package shifter_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } shift_op_e;

    localparam int DEFAULT_WIDTH      = 32;
    localparam int DEFAULT_PIPE_DEPTH = 2;

    // Mux stage k lands in slot floor(k*depth/nstages); with depth <= nstages
    // every slot receives at least one stage.
    function automatic int stage_slot(input int k, input int depth, input int nstages);
        return (k * depth) / nstages;
    endfunction

    function automatic int slot_last_stage(input int slot, input int depth, input int nstages);
        int last;
        last = 0;
        for (int k = 0; k < nstages; k++) begin
            if (stage_slot(k, depth, nstages) == slot) begin
                last = k;
            end
        end
        return last;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
// One combinational mux level of the log2 barrel shifter: shifts/rotates by
// 2**STAGE when shift_en is set, otherwise passes the operand through.
// Optional carry (macro BARREL_SHIFT_CARRY_EN): the carry of the last active
// stage in the chain is the last bit shifted out of the whole operation, so
// an inactive stage forwards carry_in unchanged.
// Ports:
//   in_data   [WIDTH]  operand entering this level
//   shift_en           shift-amount bit for this level
//   op                 operation (shift_op_e)
//   carry_in/carry_out carry chain (only with BARREL_SHIFT_CARRY_EN)
//   out_data  [WIDTH]  result of this level
// -----------------------------------------------------------------------------
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STAGE = 0
) (
    input  logic [WIDTH-1:0] in_data,
    input  logic             shift_en,
    input  shift_op_e        op,
`ifdef BARREL_SHIFT_CARRY_EN
    input  logic             carry_in,
    output logic             carry_out,
`endif
    output logic [WIDTH-1:0] out_data
);

    localparam int N = 1 << STAGE;

    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = in_data;
        case (op)
            OP_SLL:  shifted = in_data << N;
            OP_SRL:  shifted = in_data >> N;
            // Arithmetic shift keeps the MSB, so the original sign bit is
            // carried stage to stage without a separate flag.
            OP_SRA:  shifted = $signed(in_data) >>> N;
            OP_ROL:  shifted = (in_data << N) | (in_data >> (WIDTH - N));
            default: shifted = in_data;
        endcase
    end

    assign out_data = shift_en ? shifted : in_data;

`ifdef BARREL_SHIFT_CARRY_EN
    logic pick;

    // SLL/ROL lose in_data[WIDTH-N] (for ROL it becomes result[0]);
    // SRL/SRA lose in_data[N-1].
    always_comb begin
        pick = 1'b0;
        case (op)
            OP_SLL:  pick = in_data[WIDTH-N];
            OP_SRL:  pick = in_data[N-1];
            OP_SRA:  pick = in_data[N-1];
            OP_ROL:  pick = in_data[WIDTH-N];
            default: pick = 1'b0;
        endcase
    end

    assign carry_out = shift_en ? pick : carry_in;
`endif

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_barrel_shifter
// Elastic, valid/ready pipelined log2 barrel shifter (SLL, SRL, SRA, ROL).
// SHAMT_W mux stages are spread over PIPE_DEPTH register slots; latency is
// PIPE_DEPTH cycles, throughput one result per cycle.
// Optional feature macro: BARREL_SHIFT_CARRY_EN (pipelined last-bit-out carry;
// without it out_carry is tied low and no carry flops exist).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_data, in_shamt,    operand, shift amount, op (00 SLL 01 SRL 10 SRA 11 ROL)
//   in_op
//   out_valid/out_ready   output handshake
//   out_data, out_carry   result and carry
// -----------------------------------------------------------------------------
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int SHAMT_W    = $clog2(WIDTH),
    parameter int PIPE_DEPTH = DEFAULT_PIPE_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_carry
);

    // Slot registers
    logic [WIDTH-1:0]      slot_data_reg  [PIPE_DEPTH];
    logic [SHAMT_W-1:0]    slot_shamt_reg [PIPE_DEPTH];
    shift_op_e             slot_op_reg    [PIPE_DEPTH];
    logic                  slot_valid_reg [PIPE_DEPTH];

    // What each slot would capture this cycle
    logic                  slot_up_valid  [PIPE_DEPTH];
    logic [SHAMT_W-1:0]    slot_up_shamt  [PIPE_DEPTH];
    shift_op_e             slot_up_op     [PIPE_DEPTH];
    logic [WIDTH-1:0]      slot_next_data [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] slot_ready;

`ifdef BARREL_SHIFT_CARRY_EN
    logic                  slot_carry_reg  [PIPE_DEPTH];
    logic                  slot_next_carry [PIPE_DEPTH];
`endif

    // A slot can load when it is empty or when every slot downstream of it
    // moves too; that is any empty slot at or after it, or out_ready.
    // Written flat (no recursion) so the ready path has no comb self-loop.
    always_comb begin
        slot_ready = '0;
        for (int s = 0; s < PIPE_DEPTH; s++) begin
            slot_ready[s] = out_ready;
            for (int j = s; j < PIPE_DEPTH; j++) begin
                if (!slot_valid_reg[j]) begin
                    slot_ready[s] = 1'b1;
                end
            end
        end
    end

    assign in_ready = slot_ready[0];

    // Mux stages
    genvar gi;
    for (gi = 0; gi < SHAMT_W; gi++) begin : g_stage
        localparam int SL   = stage_slot(gi, PIPE_DEPTH, SHAMT_W);
        localparam bit HEAD = (gi == 0) || (stage_slot(gi - 1, PIPE_DEPTH, SHAMT_W) != SL);

        logic [WIDTH-1:0] d_in;
        logic [WIDTH-1:0] d_out;

        if (HEAD && SL == 0) begin : g_src_in
            assign d_in = in_data;
        end else if (HEAD) begin : g_src_slot
            assign d_in = slot_data_reg[SL-1];
        end else begin : g_src_chain
            assign d_in = g_stage[gi-1].d_out;
        end

`ifdef BARREL_SHIFT_CARRY_EN
        logic c_in;
        logic c_out;

        if (HEAD && SL == 0) begin : g_cin_zero
            assign c_in = 1'b0;
        end else if (HEAD) begin : g_cin_slot
            assign c_in = slot_carry_reg[SL-1];
        end else begin : g_cin_chain
            assign c_in = g_stage[gi-1].c_out;
        end
`endif

        shift_stage #(
            .WIDTH (WIDTH),
            .STAGE (gi)
        ) u_stage (
            .in_data   (d_in),
            .shift_en  (slot_up_shamt[SL][gi]),
            .op        (slot_up_op[SL]),
`ifdef BARREL_SHIFT_CARRY_EN
            .carry_in  (c_in),
            .carry_out (c_out),
`endif
            .out_data  (d_out)
        );
    end

    // Slot inputs
    for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_slot
        localparam int LAST = slot_last_stage(gi, PIPE_DEPTH, SHAMT_W);

        if (gi == 0) begin : g_first
            assign slot_up_valid[gi] = in_valid;
            assign slot_up_shamt[gi] = in_shamt;
            assign slot_up_op[gi]    = shift_op_e'(in_op);
        end else begin : g_next
            assign slot_up_valid[gi] = slot_valid_reg[gi-1];
            assign slot_up_shamt[gi] = slot_shamt_reg[gi-1];
            assign slot_up_op[gi]    = slot_op_reg[gi-1];
        end

        assign slot_next_data[gi] = g_stage[LAST].d_out;
`ifdef BARREL_SHIFT_CARRY_EN
        assign slot_next_carry[gi] = g_stage[LAST].c_out;
`endif
    end

    // Payload only loads with a valid beat so a stalled or drained output
    // keeps its last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < PIPE_DEPTH; s++) begin
                slot_valid_reg[s] <= 1'b0;
                slot_data_reg[s]  <= '0;
                slot_shamt_reg[s] <= '0;
                slot_op_reg[s]    <= OP_SLL;
            end
        end else begin
            for (int s = 0; s < PIPE_DEPTH; s++) begin
                if (slot_ready[s]) begin
                    slot_valid_reg[s] <= slot_up_valid[s];
                    if (slot_up_valid[s]) begin
                        slot_data_reg[s]  <= slot_next_data[s];
                        slot_shamt_reg[s] <= slot_up_shamt[s];
                        slot_op_reg[s]    <= slot_up_op[s];
                    end
                end
            end
        end
    end

`ifdef BARREL_SHIFT_CARRY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < PIPE_DEPTH; s++) begin
                slot_carry_reg[s] <= 1'b0;
            end
        end else begin
            for (int s = 0; s < PIPE_DEPTH; s++) begin
                if (slot_ready[s] && slot_up_valid[s]) begin
                    slot_carry_reg[s] <= slot_next_carry[s];
                end
            end
        end
    end

    assign out_carry = slot_carry_reg[PIPE_DEPTH-1];
`else
    assign out_carry = 1'b0;
`endif

    assign out_valid = slot_valid_reg[PIPE_DEPTH-1];
    assign out_data  = slot_data_reg[PIPE_DEPTH-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// tb_pipelined_barrel_shifter
// Scoreboard bench: accepted inputs push a reference result into a queue, a
// negedge monitor pops and compares each output beat, and also checks latency,
// hold-under-stall and throughput. Reference is plain shift arithmetic.
// -----------------------------------------------------------------------------
module tb_pipelined_barrel_shifter;
    import shifter_pkg::*;

    localparam int WIDTH      = 32;
    localparam int SHAMT_W    = 5;
    localparam int PIPE_DEPTH = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_op;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_carry;

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(
        .WIDTH      (WIDTH),
        .PIPE_DEPTH (PIPE_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             carry;
        int               cyc;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int push_count = 0;
    int out_count = 0;
    bit lat_check = 0;
    bit tp_mode = 0;
    int tp_count = 0;
    int tp_first = 0;
    int tp_last = 0;
    bit prev_stall = 0;
    logic [WIDTH-1:0] prev_data;
    logic prev_carry;

    // Reference: result and last bit shifted out, straight from the op rules.
    function automatic logic [WIDTH:0] ref_shift(input logic [WIDTH-1:0] d, input int s,
                                                 input logic [1:0] op);
        logic [WIDTH-1:0] r;
        logic c;
        case (op)
            2'b00:   r = d << s;
            2'b01:   r = d >> s;
            2'b10:   r = WIDTH'($signed(d) >>> s);
            default: r = (s == 0) ? d : ((d << s) | (d >> (WIDTH - s)));
        endcase
        if (s == 0) begin
            c = 1'b0;
        end else begin
            case (op)
                2'b00:   c = d[WIDTH - s];
                2'b01:   c = d[s - 1];
                2'b10:   c = d[s - 1];
                default: c = r[0];
            endcase
        end
`ifndef BARREL_SHIFT_CARRY_EN
        c = 1'b0;
`endif
        return {c, r};
    endfunction

    always @(posedge clk) cycle <= cycle + 1;

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        logic [WIDTH:0] m;
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!out_valid || out_data !== prev_data || out_carry !== prev_carry) begin
                    errors++;
                    $display("FAIL hold_under_stall got v=%b d=%h c=%b required v=1 d=%h c=%b",
                             out_valid, out_data, out_carry, prev_data, prev_carry);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_carry = out_carry;

            if (out_valid && out_ready) begin
                out_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got d=%h required no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_carry !== e.carry) begin
                        errors++;
                        $display("FAIL result got d=%h c=%b required d=%h c=%b",
                                 out_data, out_carry, e.data, e.carry);
                    end else begin
                        $display("ok result d=%h c=%b", out_data, out_carry);
                    end
                    if (lat_check) begin
                        checks++;
                        if (cycle - e.cyc != PIPE_DEPTH) begin
                            errors++;
                            $display("FAIL latency got %0d required %0d", cycle - e.cyc, PIPE_DEPTH);
                        end
                    end
                end
                if (tp_mode) begin
                    if (tp_count == 0) tp_first = cycle;
                    tp_last = cycle;
                    tp_count++;
                end
            end

            if (in_valid && in_ready) begin
                m = ref_shift(in_data, int'(in_shamt), in_op);
                e.data  = m[WIDTH-1:0];
                e.carry = m[WIDTH];
                e.cyc   = cycle;
                exp_q.push_back(e);
                push_count++;
            end
        end
    end

    task automatic issue(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] s,
                         input logic [1:0] o);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_op    = o;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int oc;
        bit rnd_done;

        // 1. reset with in_valid high
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = $urandom;
        in_shamt  = 5'd3;
        in_op     = 2'b00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h required 0", out_data); end
        checks++;
        if (out_carry !== 1'b0) begin errors++; $display("FAIL reset_out_carry got %b required 0", out_carry); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (out_count != 0) begin errors++; $display("FAIL reset_leak got %0d outputs required 0", out_count); end

        // 2/3. directed ops and boundaries, latency checked
        lat_check = 1;
        issue(32'h8000_0001, 5'd4, OP_SLL);
        issue(32'h8000_0001, 5'd4, OP_SRL);
        issue(32'h8000_0001, 5'd4, OP_SRA);
        issue(32'h8000_0001, 5'd4, OP_ROL);
        for (int o = 0; o < 4; o++) issue($urandom, 5'd0, 2'(o));
        issue(32'h0000_0003, 5'd31, OP_SLL);
        issue(32'h8000_0000, 5'd31, OP_SRA);
        issue(32'hC000_0001, 5'd31, OP_SRL);
        issue(32'h8000_0002, 5'd31, OP_ROL);
        drain();
        lat_check = 0;

        // 4. backpressure: 8 back-to-back with output stalled for 5 cycles
        base = push_count;
        oc   = out_count;
        fork
            begin
                for (int i = 0; i < 8; i++) issue($urandom, 5'($urandom), 2'($urandom));
            end
            begin
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                @(negedge clk);
                checks++;
                if (push_count - base != PIPE_DEPTH) begin
                    errors++;
                    $display("FAIL stall_accepts got %0d required %0d", push_count - base, PIPE_DEPTH);
                end
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b required 0", in_ready); end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (out_count - oc != 8) begin errors++; $display("FAIL bp_count got %0d required 8", out_count - oc); end

        // random traffic with random backpressure
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    issue($urandom, 5'($urandom), 2'($urandom));
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // 5. throughput
        lat_check = 1;
        tp_mode   = 1;
        tp_count  = 0;
        for (int i = 0; i < 100; i++) issue($urandom, 5'($urandom), 2'($urandom));
        drain();
        tp_mode = 0;
        checks++;
        if (tp_count != 100) begin errors++; $display("FAIL tp_count got %0d required 100", tp_count); end
        checks++;
        if (tp_last - tp_first != 99) begin errors++; $display("FAIL tp_span got %0d required 99", tp_last - tp_first); end

        // 6. reset with two results in flight
        lat_check = 0;
        out_ready = 1'b0;
        issue($urandom, 5'd7, OP_SRA);
        issue($urandom, 5'd9, OP_ROL);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        oc = out_count;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (out_count != oc) begin errors++; $display("FAIL flush_leak got %0d outputs required 0", out_count - oc); end
        lat_check = 1;
        issue(32'h1234_5678, 5'd13, OP_ROL);
        drain();
        checks++;
        if (out_count != oc + 1) begin errors++; $display("FAIL post_reset_count got %0d required 1", out_count - oc); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
